// File: rtl/arb_mux_pkg.sv
// Shared helpers for the arbitrated multiplexer: index-width sizing and one-hot decode.
// Define ARB_MUX_FIXED_PRIO_EN to build the arbiter as fixed priority instead of round-robin.
package arb_mux_pkg;

    localparam int unsigned MAX_N = 64;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned onehot_idx(input logic [MAX_N-1:0] v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter that owns the search pointer; round-robin by default,
// lowest-index-wins when ARB_MUX_FIXED_PRIO_EN is defined.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr;

    always_comb begin
        logic found;
        int unsigned idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign gnt_idx = IW'(onehot_idx(MAX_N'(gnt)));

`ifdef ARB_MUX_FIXED_PRIO_EN
    // Pointer pinned at zero so the search always starts from channel 0.
    always_ff @(posedge clk) begin
        if (rst || advance) ptr <= '0;
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && (|req)) begin
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated mux with a one-word registered output and valid/ready on every port.
// Build option: ARB_MUX_FIXED_PRIO_EN selects fixed-priority arbitration.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned IW = idx_w(N);

    logic          load;
    logic          advance;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic [WIDTH-1:0] sel_data;

    assign load     = !out_valid || out_ready;
    assign advance  = load && !rst;
    assign in_ready = advance ? gnt : '0;

    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (advance),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (|gnt) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: reference model of the arbitration rules checked every cycle,
// plus directed literal expectations along the stimulus sequence.
module tb_arb_mux;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_valid;
    logic           out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    arb_mux #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: winner is the first valid channel met walking upward from the pointer.
    int            m_ptr = 0;
    logic          m_valid = 1'b0;
    logic [W-1:0]  m_data = '0;
    int            m_sel = 0;

    function automatic int exp_grant(input logic [N-1:0] v, input int p);
        int start;
        start = p;
`ifdef ARB_MUX_FIXED_PRIO_EN
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] chan_data(input int i);
        return in_data[i*W +: W];
    endfunction

    always @(posedge clk) begin : model
        int g;
        g = exp_grant(in_valid, m_ptr);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (!m_valid || out_ready) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = chan_data(g);
                m_sel   = g;
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        logic [N-1:0] er;
        g  = exp_grant(in_valid, m_ptr);
        er = '0;
        if (!rst && (!m_valid || out_ready) && g >= 0) er[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(er));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_sel", 64'(out_sel), 64'(m_sel));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input int sel, input logic [W-1:0] d);
        check({name, ".valid"}, 64'(out_valid), 64'(v));
        check({name, ".sel"}, 64'(out_sel), 64'(sel));
        check({name, ".data"}, 64'(out_data), 64'(d));
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic         ready;
    } vec_t;

    vec_t tail [12] = '{
        '{4'b1010, 1'b1}, '{4'b1010, 1'b1}, '{4'b0110, 1'b0}, '{4'b0110, 1'b1},
        '{4'b1111, 1'b1}, '{4'b0001, 1'b0}, '{4'b1001, 1'b1}, '{4'b0000, 1'b1},
        '{4'b0100, 1'b1}, '{4'b1100, 1'b0}, '{4'b1100, 1'b1}, '{4'b1111, 1'b1}
    };

    initial begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        tick();
        expect_out("reset", 1'b0, 0, 32'h0);
        rst = 1'b0;

`ifndef ARB_MUX_FIXED_PRIO_EN
        // Reset order, then full round-robin wrap.
        tick(); expect_out("rr0", 1'b1, 0, 32'hA0);
        tick(); expect_out("rr1", 1'b1, 1, 32'hA1);
        tick(); expect_out("rr2", 1'b1, 2, 32'hA2);
        tick(); expect_out("rr3", 1'b1, 3, 32'hA3);
        tick(); expect_out("rr4", 1'b1, 0, 32'hA0);

        // Backpressure holding 0xA1.
        tick(); expect_out("bp_load", 1'b1, 1, 32'hA1);
        out_ready = 1'b0;
        #1 check("bp_in_ready", 64'(in_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("bp_hold", 1'b1, 1, 32'hA1);
            check("bp_in_ready_hold", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        tick(); expect_out("bp_release", 1'b1, 2, 32'hA2);

        // Bring pointer to 1, then sparse request from ch3 only.
        in_valid = 4'b0001;
        tick(); expect_out("to_ptr1", 1'b1, 0, 32'hA0);
        in_valid = 4'b1000;
        in_data[3*W +: W] = 32'h55;
        tick(); expect_out("sparse", 1'b1, 3, 32'h55);
        in_data[3*W +: W] = 32'hA3;
        in_valid = 4'b1111;
        tick(); expect_out("ptr_wrapped", 1'b1, 0, 32'hA0);

        // Idle drain.
        in_valid = 4'b0000;
        tick(); expect_out("idle", 1'b0, 0, 32'hA0);

        // Reset while holding a stalled word.
        in_valid = 4'b1111;
        tick(); expect_out("pre_rst", 1'b1, 1, 32'hA1);
        out_ready = 1'b0;
        rst = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'h0);
        tick(); expect_out("mid_rst", 1'b0, 0, 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick(); expect_out("post_rst", 1'b1, 0, 32'hA0);
`else
        in_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("fixed", 1'b1, 0, 32'hA0);
        end
`endif

        foreach (tail[i]) begin
            in_valid  = tail[i].valid;
            out_ready = tail[i].ready;
            tick();
        end
        in_valid = '0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
